sobel_stream_engine: RTL

Streaming, parametrised successor to the frame-memory Sobel system. It accepts a raster-order grayscale frame over a valid/ready stream and emits the (WIDTH-2)×(HEIGHT-2) interior edge map over a second valid/ready stream. Four selectable output modes are supported: L1 magnitude, |Gx|, |Gy| and binary threshold. It sits between a pixel source (camera/DMA) and a frame sink. It reports done and a total cycle count per frame.

---
 rtl/sobel_pkg.sv | 29 ++
 rtl/sobel_line_buffer.sv | 24 ++
 rtl/sobel_stream_engine.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types and helpers for the streaming Sobel engine.
package sobel_pkg;

    typedef enum logic [1:0] {
        MODE_L1  = 2'd0,
        MODE_GX  = 2'd1,
        MODE_GY  = 2'd2,
        MODE_THR = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    // Signed gradient width: a 3x3 Sobel kernel sums to at most 4*(2^PIX_W-1).
    function automatic int grad_w(input int pix_w);
        return pix_w + 3;
    endfunction

    function automatic logic [31:0] saturate(input logic [31:0] v, input int pix_w);
        logic [31:0] max_v;
        max_v = (32'd1 << pix_w) - 32'd1;
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image row of pixels; reading and writing the same column returns the
// pixel stored there one row earlier.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int WIDTH = 240,
    parameter int PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     shift_en_i,
    input  logic [$clog2(WIDTH)-1:0] col_i,
    input  logic [PIX_W-1:0]         din_i,
    output logic [PIX_W-1:0]         dout_o
);

    logic [PIX_W-1:0] mem_q [WIDTH];

    assign dout_o = mem_q[col_i];

    always_ff @(posedge clk) begin
        if (shift_en_i) mem_q[col_i] <= din_i;
    end

endmodule

// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel edge detector: raster pixels in, interior edge map out,
// three-stage pipeline (window, gradients, output) on a single enable.
module sobel_stream_engine
    import sobel_pkg::*;
#(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 240,
    parameter int PIX_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] threshold,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_pixel,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_pixel,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic [31:0]      total_cycles_out
);

    localparam int GW = grad_w(PIX_W);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    state_e               state_q;
    mode_e                mode_q;
    logic [PIX_W-1:0]     thr_q;
    logic [CW-1:0]        col_q;
    logic [RW-1:0]        row_q;
    logic [31:0]          cyc_q;
    logic [2:0]           vld_pipe_q, last_pipe_q;
    logic [PIX_W-1:0]     win_q [3][3];
    logic signed [GW-1:0] gx_q, gy_q, gx_d, gy_d;
    logic [PIX_W-1:0]     m_pixel_q, out_d, top_pix, mid_pix;
    logic [GW-1:0]        xr, xl, yb, yt, ax, ay, sum;
    logic                 en, accept, col_end, frame_end, win_vld;

    assign en        = !vld_pipe_q[2] || m_ready;
    assign s_ready   = (state_q == S_RUN) && en;
    assign accept    = s_valid && s_ready;
    assign col_end   = (col_q == CW'(WIDTH - 1));
    assign frame_end = col_end && (row_q == RW'(HEIGHT - 1));
    assign win_vld   = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_L1;
            thr_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            cyc_q   <= '0;
        end else begin
            if (busy) cyc_q <= cyc_q + 32'd1;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        mode_q  <= mode_e'(mode);
                        thr_q   <= threshold;
                        col_q   <= '0;
                        row_q   <= '0;
                        cyc_q   <= '0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        col_q <= col_end ? '0 : col_q + CW'(1);
                        if (col_end) row_q <= row_q + RW'(1);
                        if (frame_end) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (m_valid && m_ready && m_last) state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Row 0 of the window is the oldest line; the newest pixel enters row 2.
    sobel_line_buffer #(.WIDTH(WIDTH), .PIX_W(PIX_W)) u_lb_mid (
        .clk(clk), .shift_en_i(accept), .col_i(col_q), .din_i(s_pixel), .dout_o(mid_pix)
    );
    sobel_line_buffer #(.WIDTH(WIDTH), .PIX_W(PIX_W)) u_lb_top (
        .clk(clk), .shift_en_i(accept), .col_i(col_q), .din_i(mid_pix), .dout_o(top_pix)
    );

    always_comb begin
        xr   = GW'(win_q[0][2]) + (GW'(win_q[1][2]) << 1) + GW'(win_q[2][2]);
        xl   = GW'(win_q[0][0]) + (GW'(win_q[1][0]) << 1) + GW'(win_q[2][0]);
        yb   = GW'(win_q[2][0]) + (GW'(win_q[2][1]) << 1) + GW'(win_q[2][2]);
        yt   = GW'(win_q[0][0]) + (GW'(win_q[0][1]) << 1) + GW'(win_q[0][2]);
        gx_d = signed'(xr - xl);
        gy_d = signed'(yb - yt);
    end

    always_comb begin
        ax  = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
        ay  = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
        sum = ax + ay;
        case (mode_q)
            MODE_GX:  out_d = PIX_W'(saturate(32'(ax), PIX_W));
            MODE_GY:  out_d = PIX_W'(saturate(32'(ay), PIX_W));
            MODE_THR: out_d = (sum >= GW'(thr_q)) ? '1 : '0;
            default:  out_d = PIX_W'(saturate(32'(sum), PIX_W));
        endcase
    end

    // Datapath registers carry no reset; the valid pipe alone qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= top_pix;
            win_q[1][2] <= mid_pix;
            win_q[2][2] <= s_pixel;
        end
        if (en) begin
            gx_q <= gx_d;
            gy_q <= gy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            m_pixel_q   <= '0;
        end else if (en) begin
            vld_pipe_q  <= {vld_pipe_q[1:0], win_vld};
            last_pipe_q <= {last_pipe_q[1:0], accept && frame_end};
            if (vld_pipe_q[1]) m_pixel_q <= out_d;
        end
    end

    assign m_valid          = vld_pipe_q[2];
    assign m_last           = last_pipe_q[2];
    assign m_pixel          = m_pixel_q;
    assign busy             = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done             = (state_q == S_DONE);
    assign total_cycles_out = cyc_q;

endmodule
